// File: rtl/el2_pkg.sv
// Shared types for the DCCM memory-BIST controller.
package el2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_P,
    RD_P,
    WR_N,
    RD_N,
    FLUSH,
    DONE
  } el2_mbist_state_t;

  localparam logic [1:0] MBIST_PAT_SEED = 2'b01;

endpackage

// File: rtl/el2_dccm_mbist_cmp.sv
// Pattern generator for the issuing op and per-bank compare for the op issued last cycle.
module el2_dccm_mbist_cmp
  import el2_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int FDATA_W   = 39,
  parameter int IW        = 12
) (
  input  logic [IW-1:0]                  issue_idx,
  input  logic                           issue_phase,
  input  logic [IW-1:0]                  pend_idx,
  input  logic                           pend_phase,
  input  logic [NUM_BANKS*FDATA_W-1:0]   mem_rdata,
  output logic [FDATA_W-1:0]             issue_pat,
  output logic [NUM_BANKS-1:0]           mismatch
);

  // Inverted phase re-applies the index XOR, so it cancels out.
  function automatic logic [FDATA_W-1:0] gen_pat(input logic [IW-1:0] idx, input logic phase);
    logic [FDATA_W-1:0] p;
    for (int i = 0; i < FDATA_W; i++) begin
      p[i] = i[0] ? MBIST_PAT_SEED[1] : MBIST_PAT_SEED[0];
    end
    p = p ^ FDATA_W'(idx);
    if (phase) begin
      p = ~p ^ FDATA_W'(idx);
    end
    return p;
  endfunction

  logic [FDATA_W-1:0] exp_pat;

  always_comb begin
    issue_pat = gen_pat(issue_idx, issue_phase);
    exp_pat   = gen_pat(pend_idx, pend_phase);
    mismatch  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      mismatch[b] = |(mem_rdata[b*FDATA_W +: FDATA_W] ^ exp_pat);
    end
  end

endmodule

// File: rtl/el2_dccm_mbist_ctrl.sv
// DCCM memory-BIST sequencer: steals core-idle cycles to run a write/read-compare March over all banks.
// state | meaning: IDLE wait | WR_P/RD_P write/check P | WR_N/RD_N write/check N | FLUSH drain | DONE result held
module el2_dccm_mbist_ctrl
  import el2_pkg::*;
#(
  parameter int   NUM_BANKS   = 4,
  parameter int   INDEX_DEPTH = 4096,
  parameter int   FDATA_W     = 39,
  localparam int  IW          = $clog2(INDEX_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic                          start,
  input  logic [NUM_BANKS-1:0]          core_clken,
  input  logic [NUM_BANKS-1:0]          core_wren,
  input  logic [NUM_BANKS*IW-1:0]       core_addr,
  input  logic [NUM_BANKS*FDATA_W-1:0]  core_wdata,
  output logic [NUM_BANKS*FDATA_W-1:0]  core_rdata,
  output logic [NUM_BANKS-1:0]          mem_clken,
  output logic [NUM_BANKS-1:0]          mem_wren,
  output logic [NUM_BANKS*IW-1:0]       mem_addr,
  output logic [NUM_BANKS*FDATA_W-1:0]  mem_wdata,
  input  logic [NUM_BANKS*FDATA_W-1:0]  mem_rdata,
  output logic                          busy,
  output logic                          done,
  output logic                          fail,
  output logic [NUM_BANKS-1:0]          fail_bank,
  output logic [IW-1:0]                 fail_index,
  output logic                          fail_phase
);

  el2_mbist_state_t     state_q, state_d;
  logic [IW-1:0]        index_q, index_d;
  logic                 pend_q, pend_d;
  logic [IW-1:0]        pend_idx_q, pend_idx_d;
  logic                 pend_phase_q, pend_phase_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 fail_q, fail_d;
  logic [NUM_BANKS-1:0] fail_bank_q, fail_bank_d;
  logic [IW-1:0]        fail_index_q, fail_index_d;
  logic                 fail_phase_q, fail_phase_d;

  logic                 issue, is_rd, phase_n, last, hit, can_start;
  logic [FDATA_W-1:0]   issue_pat;
  logic [NUM_BANKS-1:0] mismatch;

  el2_dccm_mbist_cmp #(
    .NUM_BANKS (NUM_BANKS),
    .FDATA_W   (FDATA_W),
    .IW        (IW)
  ) u_cmp (
    .issue_idx   (index_q),
    .issue_phase (phase_n),
    .pend_idx    (pend_idx_q),
    .pend_phase  (pend_phase_q),
    .mem_rdata   (mem_rdata),
    .issue_pat   (issue_pat),
    .mismatch    (mismatch)
  );

  always_comb begin
    is_rd     = (state_q == RD_P) || (state_q == RD_N);
    phase_n   = (state_q == WR_N) || (state_q == RD_N);
    issue     = (core_clken == '0) && (state_q inside {WR_P, RD_P, WR_N, RD_N});
    last      = (index_q == IW'(INDEX_DEPTH - 1));
    hit       = pend_q && (mismatch != '0);
    can_start = start && ((state_q == IDLE) || (state_q == DONE));

    state_d      = state_q;
    index_d      = index_q;
    pend_d       = issue && is_rd;
    pend_idx_d   = index_q;
    pend_phase_d = phase_n;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    fail_bank_d  = fail_bank_q;
    fail_index_d = fail_index_q;
    fail_phase_d = fail_phase_q;

    if (can_start) begin
      state_d      = WR_P;
      index_d      = '0;
      pend_d       = 1'b0;
      busy_d       = 1'b1;
      done_d       = 1'b0;
      fail_d       = 1'b0;
      fail_bank_d  = '0;
      fail_index_d = '0;
      fail_phase_d = 1'b0;
    end else if (hit) begin
      // Any op issued alongside the failing compare is dropped by clearing pend.
      state_d      = DONE;
      pend_d       = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b1;
      fail_d       = 1'b1;
      fail_bank_d  = mismatch;
      fail_index_d = pend_idx_q;
      fail_phase_d = pend_phase_q;
    end else begin
      if (issue) begin
        index_d = last ? '0 : index_q + IW'(1);
        if (last) begin
          unique case (state_q)
            WR_P:    state_d = RD_P;
            RD_P:    state_d = WR_N;
            WR_N:    state_d = RD_N;
            RD_N:    state_d = FLUSH;
            default: state_d = state_q;
          endcase
        end
      end
      if (state_q == FLUSH) begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= IDLE;
      index_q      <= '0;
      pend_q       <= 1'b0;
      pend_idx_q   <= '0;
      pend_phase_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_bank_q  <= '0;
      fail_index_q <= '0;
      fail_phase_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      pend_q       <= pend_d;
      pend_idx_q   <= pend_idx_d;
      pend_phase_q <= pend_phase_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      fail_bank_q  <= fail_bank_d;
      fail_index_q <= fail_index_d;
      fail_phase_q <= fail_phase_d;
    end
  end

  always_comb begin
    mem_clken = core_clken;
    mem_wren  = core_wren;
    mem_addr  = core_addr;
    mem_wdata = core_wdata;
    if (issue) begin
      mem_clken = '1;
      mem_wren  = is_rd ? '0 : '1;
      mem_addr  = {NUM_BANKS{index_q}};
      mem_wdata = {NUM_BANKS{issue_pat}};
    end
  end

  assign core_rdata = mem_rdata;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign fail_bank  = fail_bank_q;
  assign fail_index = fail_index_q;
  assign fail_phase = fail_phase_q;

endmodule
